fetch_addr_gen: RTL and testbench

//  Consumer side of the next-PC path: takes the PC register value, fetches the instruction word

---
 rtl/fetch_addr_gen.sv | 108 ++++++++++
 tb/tb_fetch_addr_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_addr_gen.sv
// Instruction fetch and next-PC address generator for a multicycle CPU.
// Fetches one word at a time over a req/ack port and registers PC+4, branch and jump targets.
module fetch_addr_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_load,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ack,
  output logic [31:0] pc4,
  output logic [31:0] branch_addr,
  output logic [31:0] jump_addr,
  output logic        busy,
  output logic        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, CALC, VALID} state_t;

  state_t        state;
  logic [31:0]   pc_q;
  logic [31:0]   ir;
  logic [CW-1:0] cnt;

  logic [31:0] pc4_n;
  logic [31:0] br_off;
  logic        take;
  logic        aligned;

  assign pc4_n   = pc_q + 32'd4;
  assign br_off  = {{14{ir[15]}}, ir[15:0], 2'b00};
  // a new PC is accepted only when idle, or when control retires the held instruction
  assign take    = pc_load && ((state == IDLE) || ((state == VALID) && instr_ack));
  assign aligned = (pc[1:0] == 2'b00);

  assign mem_addr = pc_q;
  assign instr    = ir;
  assign busy     = (state == REQ) || (state == CALC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc_q        <= RESET_PC;
      ir          <= '0;
      cnt         <= '0;
      mem_req     <= 1'b0;
      instr_valid <= 1'b0;
      pc4         <= RESET_PC + 32'd4;
      branch_addr <= '0;
      jump_addr   <= '0;
      fetch_err   <= 1'b0;
    end else begin
      fetch_err <= 1'b0;
      case (state)
        IDLE: ;
        REQ: begin
          if (mem_ack) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= CALC;
          end else if (cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            fetch_err <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CALC: begin
          pc4         <= pc4_n;
          branch_addr <= pc4_n + br_off;
          jump_addr   <= {pc4_n[31:28], ir[25:0], 2'b00};
          instr_valid <= 1'b1;
          state       <= VALID;
        end
        VALID: begin
          if (instr_ack) begin
            instr_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // placed after the case so a back-to-back fetch from VALID overrides the IDLE return
      if (take) begin
        if (aligned) begin
          pc_q    <= pc;
          cnt     <= '0;
          mem_req <= 1'b1;
          state   <= REQ;
        end else begin
          fetch_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_addr_gen.sv
// Directed bench for fetch_addr_gen: vector table of full fetches plus
// hand-written sequences for misalignment, timeout, ignored loads and mid-fetch reset.
module tb_fetch_addr_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_load = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack = 1'b0;
  logic [31:0] pc4, branch_addr, jump_addr;
  logic        busy, fetch_err;

  int total = 0;
  int bad   = 0;

  fetch_addr_gen #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .pc(pc), .pc_load(pc_load),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ack(instr_ack),
    .pc4(pc4), .branch_addr(branch_addr), .jump_addr(jump_addr),
    .busy(busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] rd;
    int          dly;
    logic [31:0] pc4;
    logic [31:0] br;
    logic [31:0] jmp;
  } vec_t;

  vec_t vt[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // full fetch: load, hold REQ for dly cycles, ack, check CALC/VALID, retire
  task automatic run_vec(input vec_t v);
    pc = v.pc; pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    check("req_start", {31'd0, mem_req}, 32'd1);
    check("mem_addr", mem_addr, v.pc);
    check("busy_req", {31'd0, busy}, 32'd1);
    repeat (v.dly) tick();
    check("req_held", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = v.rd;
    tick();
    mem_ack = 1'b0;
    check("req_drop", {31'd0, mem_req}, 32'd0);
    check("calc_nvalid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("valid", {31'd0, instr_valid}, 32'd1);
    check("instr", instr, v.rd);
    check("pc4", pc4, v.pc4);
    check("branch", branch_addr, v.br);
    check("jump", jump_addr, v.jmp);
    check("busy_valid", {31'd0, busy}, 32'd0);
    tick();
    check("valid_hold", {31'd0, instr_valid}, 32'd1);
    instr_ack = 1'b1;
    tick();
    instr_ack = 1'b0;
    check("valid_drop", {31'd0, instr_valid}, 32'd0);
  endtask

  initial begin
    int n;
    vt[0] = '{pc: 32'h0000_0040, rd: 32'h1000_0003, dly: 3,
              pc4: 32'h0000_0044, br: 32'h0000_0050, jmp: 32'h0000_000C};
    vt[1] = '{pc: 32'h0000_0100, rd: 32'h1000_FFFF, dly: 0,
              pc4: 32'h0000_0104, br: 32'h0000_0100, jmp: 32'h0003_FFFC};
    vt[2] = '{pc: 32'hFFFF_FFFC, rd: 32'h0000_0001, dly: 1,
              pc4: 32'h0000_0000, br: 32'h0000_0004, jmp: 32'h0000_0004};
    vt[3] = '{pc: 32'h8000_0010, rd: 32'h0BFF_8000, dly: 2,
              pc4: 32'h8000_0014, br: 32'h7FFE_0014, jmp: 32'h8FFE_0000};

    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0000_0000);
    check("rst_pc4", pc4, 32'h0000_0004);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_branch", branch_addr, 32'd0);
    check("rst_jump", jump_addr, 32'd0);

    for (int i = 0; i < 4; i++) run_vec(vt[i]);

    // misaligned PC: error pulse, no request
    pc = 32'h0000_0042; pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    check("mis_err", {31'd0, fetch_err}, 32'd1);
    check("mis_req", {31'd0, mem_req}, 32'd0);
    check("mis_busy", {31'd0, busy}, 32'd0);
    tick();
    check("mis_err_drop", {31'd0, fetch_err}, 32'd0);
    check("mis_req2", {31'd0, mem_req}, 32'd0);

    // stray ack in IDLE is ignored
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    check("stray_busy", {31'd0, busy}, 32'd0);
    check("stray_instr", instr, vt[3].rd);

    // timeout: mem_req high exactly 16 cycles
    pc = 32'h0000_0300; pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      if (fetch_err) check("to_early_err", {31'd0, fetch_err}, 32'd0);
      tick();
    end
    check("to_req_cycles", n, 32'd16);
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_instr", instr, vt[3].rd);
    tick();
    check("to_err_drop", {31'd0, fetch_err}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd0);

    // pc_load during REQ ignored; back-to-back load from VALID
    pc = 32'h0000_0040; pc_load = 1'b1;
    tick();
    pc = 32'h0000_0080;
    tick();
    pc_load = 1'b0;
    check("ign_addr", mem_addr, 32'h0000_0040);
    mem_ack = 1'b1; mem_rdata = 32'h1000_0003;
    tick();
    mem_ack = 1'b0;
    tick();
    check("ign_valid", {31'd0, instr_valid}, 32'd1);
    check("ign_pc4", pc4, 32'h0000_0044);
    pc = 32'h0000_0180; pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
    check("noack_valid", {31'd0, instr_valid}, 32'd1);
    check("noack_req", {31'd0, mem_req}, 32'd0);
    pc = 32'h0000_0200; pc_load = 1'b1; instr_ack = 1'b1;
    tick();
    pc_load = 1'b0; instr_ack = 1'b0;
    check("b2b_req", {31'd0, mem_req}, 32'd1);
    check("b2b_addr", mem_addr, 32'h0000_0200);
    check("b2b_valid", {31'd0, instr_valid}, 32'd0);

    // reset two cycles into REQ
    tick(); tick();
    check("pre_rst_req", {31'd0, mem_req}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_req", {31'd0, mem_req}, 32'd0);
    check("async_addr", mem_addr, 32'h0000_0000);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_req", {31'd0, mem_req}, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_addr", mem_addr, 32'h0000_0000);
    check("post_rst_valid", {31'd0, instr_valid}, 32'd0);

    run_vec(vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
